// File: rtl/gnss_clk_pkg.sv
// Shared constants and helpers for the GNSS code-clock generators.
// Holds the default accumulator width, the standard code lengths, and a
// constant function that turns an output frequency into an NCO step word.
package gnss_clk_pkg;

  localparam int ACC_W_DEF        = 32;
  localparam int GLONASS_CODE_LEN = 511;
  localparam int GPS_CA_CODE_LEN  = 1023;

  // Rounded phase step for f_out from f_clk with an acc_w-bit accumulator.
  // The real-to-integer cast rounds to nearest, which gives the rounding.
  function automatic longint nco_step(input real f_out, input real f_clk,
                                      input int acc_w);
    return longint'(f_out / f_clk * (2.0 ** acc_w));
  endfunction

endpackage : gnss_clk_pkg

// File: rtl/chip_cnt_mod.sv
// Modulo-N chip counter with increment, synchronous clear, and a one-cycle
// wrap strobe registered on the same edge that takes the count from N-1
// back to 0.
module chip_cnt_mod #(
  parameter int N = 511,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  // Count advances on inc, clear wins over inc, wrap pulses on the N-1 -> 0 step.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (inc) begin
      if (cnt == W'(N - 1)) begin
        cnt  <= '0;
        wrap <= 1'b1;
      end else begin
        cnt  <= cnt + 1'b1;
        wrap <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule : chip_cnt_mod

// File: rtl/gen_chip_nco.sv
// Chip-rate generator built on a single-clock phase-accumulator NCO.
// Produces a chip-enable strobe, a near-50% chip clock (accumulator MSB),
// a chip index modulo CODE_LEN and a code-epoch strobe. The step word is
// runtime loadable and the phase can be preset. Everything is a clock
// enable in the clk domain; no derived clocks are generated.
// Optional: define GEN_CHIP_NCO_HALF_CHIP_EN to add half_en_o, a strobe
// at mid-chip (MSB 0->1) and at each carry, i.e. two strobes per chip.
module gen_chip_nco
  import gnss_clk_pkg::*;
#(
  parameter int             ACC_W    = ACC_W_DEF,
  parameter int             CODE_LEN = GLONASS_CODE_LEN,
  parameter int             CNT_W    = $clog2(CODE_LEN),
  parameter logic [ACC_W-1:0] DEF_STEP = ACC_W'(nco_step(511.0e3, 50.0e6, ACC_W))
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic [ACC_W-1:0] step_i,
  input  logic             step_load_i,
  input  logic [ACC_W-1:0] phase_i,
  input  logic             phase_load_i,
  output logic             chip_en_o,
  output logic             chip_clk_o,
  output logic [CNT_W-1:0] chip_idx_o,
  output logic             epoch_o
`ifdef GEN_CHIP_NCO_HALF_CHIP_EN
  ,
  output logic             half_en_o
`endif
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] step_reg;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             advance;

  // Next accumulator value one bit wider than acc; the top bit is the carry.
  // NOTE: combinational logic uses blocking assignments and assigns every
  // output on every path, so no latch can be inferred.
  always_comb begin
    sum = {1'b0, acc} + {1'b0, step_reg};
  end

  assign carry   = sum[ACC_W];
  // Phase preset outranks accumulation, so the adder only counts when not loading.
  assign advance = enable_i && !phase_load_i;

  // Step word register: loads independently of enable and phase preset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_reg <= DEF_STEP;
    end else if (step_load_i) begin
      step_reg <= step_i;
    end
  end

  // Accumulator, chip strobe and chip clock: preset, accumulate or hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc        <= '0;
      chip_en_o  <= 1'b0;
      chip_clk_o <= 1'b0;
    end else if (phase_load_i) begin
      acc        <= phase_i;
      chip_en_o  <= 1'b0;
      chip_clk_o <= phase_i[ACC_W-1];
    end else if (enable_i) begin
      acc        <= sum[ACC_W-1:0];
      chip_en_o  <= carry;
      chip_clk_o <= sum[ACC_W-1];
    end else begin
      chip_en_o  <= 1'b0;
    end
  end

`ifdef GEN_CHIP_NCO_HALF_CHIP_EN
  // Half-chip strobe: carry, or the accumulator MSB rising from 0 to 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      half_en_o <= 1'b0;
    end else if (advance) begin
      half_en_o <= carry | (~acc[ACC_W-1] & sum[ACC_W-1]);
    end else begin
      half_en_o <= 1'b0;
    end
  end
`endif

  // Chip index and epoch strobe share the edge that raises chip_en_o.
  chip_cnt_mod #(
    .N (CODE_LEN),
    .W (CNT_W)
  ) u_chip_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (advance && carry),
    .clr   (phase_load_i),
    .cnt   (chip_idx_o),
    .wrap  (epoch_o)
  );

endmodule : gen_chip_nco

// File: doc/gen_chip_nco.md
Name: gen_chip_nco

Overview:
Parametrised chip-rate generator replacing fixed ripple-divider clock generation with a single-clock phase-accumulator NCO. Produces a one-cycle chip-enable strobe, a near-50% chip clock, a chip index modulo the code length, and a code-epoch strobe. The rate is programmable at runtime and the phase is loadable. Feeds the GLONASS/GPS code generators as a clock enable; no derived clocks enter the clock tree.

Parameters:
ACC_W, 32, accumulator width in bits.
CODE_LEN, 511, chips per code period (GLONASS C/A = 511).
CNT_W, $clog2(CODE_LEN), chip index width.
DEF_STEP, 43894566, reset step value: 0.511 MHz from a 50 MHz clk (511e3/50e6 * 2^32, rounded).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
enable_i  in  1  run/hold
step_i  in  ACC_W  frequency word
step_load_i  in  1  latch step_i
phase_i  in  ACC_W  phase preset
phase_load_i  in  1  load phase_i into accumulator
chip_en_o  out  1  one-cycle strobe per chip
chip_clk_o  out  1  registered accumulator MSB
chip_idx_o  out  CNT_W  current chip index, 0..CODE_LEN-1
epoch_o  out  1  one-cycle strobe on code wrap

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low, sampled on posedge clk.
- Reset values:
  - acc = 0, step_reg = DEF_STEP, chip_idx_o = 0.
  - chip_en_o, chip_clk_o and epoch_o are all 0.
- Accumulate, when enable_i = 1 and phase_load_i = 0:
  - {carry, acc} <= acc + step_reg, computed at ACC_W+1 bits, so the sum wraps modulo 2^ACC_W.
  - chip_en_o <= carry. The strobe is high during the cycle following the overflowing edge.
- chip_clk_o <= MSB of the next acc value.
  - Duty is 50% ±1 cycle for step < 2^(ACC_W-1).
  - Larger steps are legal; the duty cycle is then undefined.
- Chip index:
  - On carry, chip_idx_o increments.
  - At CODE_LEN-1 it wraps to 0, and epoch_o <= 1 on the same edge as that chip_en_o.
  - epoch_o is only ever high coincident with chip_en_o.
- Hold, when enable_i = 0:
  - acc, chip_idx_o and chip_clk_o hold.
  - chip_en_o and epoch_o are 0.
- step_load_i = 1:
  - step_reg <= step_i. Applies regardless of enable_i.
  - The new step is first used on the following edge; the add on the load edge uses the old step_reg.
- phase_load_i = 1:
  - Takes priority over accumulate: acc <= phase_i and chip_idx_o <= 0.
  - chip_en_o and epoch_o are 0 that cycle.
  - chip_clk_o <= phase_i[ACC_W-1].
  - Applies regardless of enable_i.
- Simultaneous step_load_i and phase_load_i: both apply.
- step_reg = 0: no strobes; the accumulator is static.
- Maximum strobe rate: one chip_en_o per cycle, and only when step_reg = 2^ACC_W-1 wraps consistently. The generator never produces two carries per cycle.
- Reset asserted mid-operation: all state returns to its reset value on that edge, including step_reg = DEF_STEP. No strobe is emitted on that edge.

Optional Feature:
GEN_CHIP_NCO_HALF_CHIP_EN
- Defined:
  - Adds output half_en_o (1 bit).
  - It pulses for one cycle when the accumulator MSB transitions 0→1 (mid-chip), and also on each carry.
  - This gives 2 strobes per chip for BOC/Manchester shaping.
  - It obeys the same enable_i, phase_load_i and reset gating as chip_en_o; reset value 0.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package gnss_clk_pkg:
  - ACC_W default.
  - GLONASS_CODE_LEN = 511 and GPS_CA_CODE_LEN = 1023.
  - Constant function nco_step(f_out, f_clk, acc_w) returning the rounded step.
- One sub-module, chip_cnt_mod: a modulo-N counter with inc, clr and wrap-strobe output, instantiated for chip_idx_o/epoch_o.

Test Plan:
- Default step, clk 50 MHz, 1,000,000 cycles after reset release -> 10220 ±1 chip_en_o pulses; each pulse is exactly 1 cycle wide.
- step_load with step_i = 2^31 -> from the 2nd cycle after the load, chip_en_o fires every 2 cycles and chip_clk_o toggles each cycle; the cycle immediately after the load still uses the old step.
- step = 2^31, run 1022 chip_en_o pulses -> chip_idx_o sequence 0..510,0..510; epoch_o high exactly twice, coincident with the chip_en_o pulses where 510→0.
- phase_load with phase_i = 2^32 - step while running at chip_idx_o = 100 -> chip_idx_o = 0, no chip_en_o that cycle; chip_en_o on the next enabled cycle and chip_idx_o = 1.
- enable_i low for 37 cycles mid-chip -> acc, chip_idx_o and chip_clk_o frozen, no strobes; on resume, pulse spacing continues as if time-shifted by 37 cycles.
- rst_n low for 1 cycle mid-run after a step_load -> all outputs 0, step_reg = DEF_STEP (verified by the default-rate pulse count); with GEN_CHIP_NCO_HALF_CHIP_EN, half_en_o gives 2 pulses per chip_en_o at step 2^30.
